// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
//   PC_RESET_DEF  - default PC after reset
//   IM_BASE_DEF   - lowest legal instruction byte address
//   IM_WORDS_DEF  - size of legal instruction space in 32-bit words
//   NOP_INSTR     - encoding injected into D for a bubble or faulting fetch
//   EXC_ADEL      - exception code for an address error on instruction fetch
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF = 4096;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register.
//   clk, reset        - clock, synchronous active-high reset
//   hold              - keep current contents (highest priority after reset)
//   bubble            - load a nop bubble tagged with f_pc
//   load              - load the fetched instruction
//   f_pc/f_instr/f_exc - fetch-side values
//   d_pc/d_instr/d_valid/d_exc - decode-side register outputs
module fetch_stage_fd_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_exc,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_valid,
  output logic        d_exc
);

  logic [31:0] pc_q, instr_q;
  logic        valid_q, exc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else if (hold) begin
      pc_q    <= pc_q;
      instr_q <= instr_q;
      valid_q <= valid_q;
      exc_q   <= exc_q;
    end else if (bubble) begin
      pc_q    <= f_pc;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else if (load) begin
      pc_q    <= f_pc;
      instr_q <= f_instr;
      valid_q <= 1'b1;
      exc_q   <= f_exc;
    end
  end

  assign d_pc    = pc_q;
  assign d_instr = instr_q;
  assign d_valid = valid_q;
  assign d_exc   = exc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, redirect latch, fetch legality
// check and the F/D pipeline register. Tolerates a variable-latency instruction memory.
//   clk, reset          - clock, synchronous active-high reset
//   stall               - freeze PC, F/D register and redirect latch
//   npc, D_jump         - next PC and taken-branch flag from the D stage
//   imem_req/imem_addr  - fetch request toward instruction memory
//   imem_ready/imem_rdata - memory response
//   F_PC                - current fetch PC
//   D_PC/D_Instr/D_valid/D_exc - F/D register contents
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        D_jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_valid,
  output logic        D_exc
);

  // 33-bit bound so a PC near 0xFFFF_FFFC cannot wrap into the legal window.
  localparam logic [32:0] ImLimit = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q, pc_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        bad_pc, fetch_done;

  assign bad_pc = (pc_q[1:0] != 2'b00)
                | ({1'b0, pc_q} < {1'b0, IM_BASE})
                | ({1'b0, pc_q} >= ImLimit);
  assign fetch_done = bad_pc | imem_ready;

  assign imem_req  = !reset && !bad_pc;
  assign imem_addr = pc_q;
  assign F_PC      = pc_q;

  always_comb begin
    pc_d          = pc_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    if (!stall) begin
      if (fetch_done) begin
        pc_d          = redir_valid_q ? redir_pc_q : npc;
        redir_valid_d = 1'b0;
      end else if (D_valid && D_jump && !redir_valid_q) begin
        // Delay slot still outstanding: remember the target until it completes.
        redir_valid_d = 1'b1;
        redir_pc_d    = npc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  fetch_stage_fd_reg #(
    .PC_RESET (PC_RESET)
  ) u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .hold    (stall),
    .bubble  (!fetch_done),
    .load    (fetch_done),
    .f_pc    (pc_q),
    .f_instr (bad_pc ? NOP_INSTR : imem_rdata),
    .f_exc   (bad_pc),
    .d_pc    (D_PC),
    .d_instr (D_Instr),
    .d_valid (D_valid),
    .d_exc   (D_exc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, D_jump, imem_ready;
  logic [31:0] npc, imem_rdata;
  logic        imem_req, D_valid, D_exc;
  logic [31:0] imem_addr, F_PC, D_PC, D_Instr;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc        (npc),
    .D_jump     (D_jump),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .F_PC       (F_PC),
    .D_PC       (D_PC),
    .D_Instr    (D_Instr),
    .D_valid    (D_valid),
    .D_exc      (D_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic        d_exc;
    logic        req;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vec_id = 0;

  localparam logic [31:0] I0 = 32'h2401_0001;
  localparam logic [31:0] I1 = 32'h1000_003f;
  localparam logic [31:0] I2 = 32'h2402_0002;
  localparam logic [31:0] I3 = 32'h2403_0003;
  localparam logic [31:0] I4 = 32'h2404_0004;
  localparam logic [31:0] I5 = 32'h2405_0005;
  localparam logic [31:0] JUNK = 32'hffff_ffff;

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s v%0d: got %h want %h", nm, tag, act, want);
    end
  endtask

  // Monitor: one edge after each vector is driven, compare DUT state to the queued entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("F_PC",      e.tag, F_PC,             e.f_pc);
        chk("imem_addr", e.tag, imem_addr,        e.f_pc);
        chk("D_PC",      e.tag, D_PC,             e.d_pc);
        chk("D_Instr",   e.tag, D_Instr,          e.d_instr);
        chk("D_valid",   e.tag, {31'b0, D_valid}, {31'b0, e.d_valid});
        chk("D_exc",     e.tag, {31'b0, D_exc},   {31'b0, e.d_exc});
        chk("imem_req",  e.tag, {31'b0, imem_req}, {31'b0, e.req});
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input logic rst, input logic st, input logic [31:0] np,
                     input logic jmp, input logic rdy, input logic [31:0] rd,
                     input logic [31:0] ef, input logic [31:0] edpc,
                     input logic [31:0] edi, input logic ev, input logic ee,
                     input logic er);
    exp_t e;
    reset      = rst;
    stall      = st;
    npc        = np;
    D_jump     = jmp;
    imem_ready = rdy;
    imem_rdata = rd;
    vec_id++;
    e.tag = vec_id; e.f_pc = ef; e.d_pc = edpc; e.d_instr = edi;
    e.d_valid = ev; e.d_exc = ee; e.req = er;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    //  rst st  npc           jmp rdy rdata  F_PC          D_PC          D_Instr v  exc req
    // Reset and sequential fetch
    cyc(1, 0, 32'h0000_3004, 0, 1, I0,   32'h3000,     32'h3000,     32'h0, 0, 0, 0);
    cyc(0, 0, 32'h0000_3004, 0, 1, I0,   32'h3004,     32'h3000,     I0,    1, 0, 1);
    cyc(0, 0, 32'h0000_3008, 0, 1, I1,   32'h3008,     32'h3004,     I1,    1, 0, 1);
    // Stall for three cycles with memory ready
    cyc(0, 1, 32'h0000_300c, 0, 1, I2,   32'h3008,     32'h3004,     I1,    1, 0, 1);
    cyc(0, 1, 32'h0000_300c, 0, 1, I2,   32'h3008,     32'h3004,     I1,    1, 0, 1);
    cyc(0, 1, 32'h0000_300c, 0, 1, I2,   32'h3008,     32'h3004,     I1,    1, 0, 1);
    // Branch in D with completing delay-slot fetch
    cyc(0, 0, 32'h0000_3100, 1, 1, I2,   32'h3100,     32'h3008,     I2,    1, 0, 1);
    // Same branch, delay-slot fetch waits two cycles
    cyc(1, 0, 32'h0000_3004, 0, 1, I0,   32'h3000,     32'h3000,     32'h0, 0, 0, 0);
    cyc(0, 0, 32'h0000_3004, 0, 1, I0,   32'h3004,     32'h3000,     I0,    1, 0, 1);
    cyc(0, 0, 32'h0000_3008, 0, 1, I1,   32'h3008,     32'h3004,     I1,    1, 0, 1);
    cyc(0, 0, 32'h0000_3100, 1, 0, JUNK, 32'h3008,     32'h3008,     32'h0, 0, 0, 1);
    cyc(0, 0, 32'h0000_300c, 0, 0, JUNK, 32'h3008,     32'h3008,     32'h0, 0, 0, 1);
    cyc(0, 0, 32'h0000_300c, 0, 1, I2,   32'h3100,     32'h3008,     I2,    1, 0, 1);
    cyc(0, 0, 32'h0000_3104, 0, 1, I3,   32'h3104,     32'h3100,     I3,    1, 0, 1);
    // Misaligned branch target
    cyc(0, 0, 32'h0000_3102, 1, 1, I4,   32'h3102,     32'h3104,     I4,    1, 0, 0);
    cyc(0, 0, 32'h0000_3106, 0, 0, JUNK, 32'h3106,     32'h3102,     32'h0, 1, 1, 0);
    cyc(0, 0, 32'h0000_310a, 0, 0, JUNK, 32'h310a,     32'h3106,     32'h0, 1, 1, 0);
    // Range boundaries: last legal word, one past end, top of space, below base
    cyc(0, 0, 32'h0000_6ffc, 0, 0, JUNK, 32'h6ffc,     32'h310a,     32'h0, 1, 1, 1);
    cyc(0, 0, 32'h0000_7000, 0, 1, I5,   32'h7000,     32'h6ffc,     I5,    1, 0, 0);
    cyc(0, 0, 32'hffff_fffc, 0, 0, JUNK, 32'hffff_fffc, 32'h7000,    32'h0, 1, 1, 0);
    cyc(0, 0, 32'h0000_2ffc, 0, 0, JUNK, 32'h2ffc,     32'hffff_fffc, 32'h0, 1, 1, 0);
    cyc(0, 0, 32'h0000_3000, 0, 0, JUNK, 32'h3000,     32'h2ffc,     32'h0, 1, 1, 1);
    // Reset while a redirect is pending discards it
    cyc(0, 0, 32'h0000_3004, 0, 1, I0,   32'h3004,     32'h3000,     I0,    1, 0, 1);
    cyc(0, 0, 32'h0000_3008, 0, 1, I1,   32'h3008,     32'h3004,     I1,    1, 0, 1);
    cyc(0, 0, 32'h0000_3100, 1, 0, JUNK, 32'h3008,     32'h3008,     32'h0, 0, 0, 1);
    cyc(1, 0, 32'h0000_3100, 0, 0, JUNK, 32'h3000,     32'h3000,     32'h0, 0, 0, 0);
    cyc(0, 0, 32'h0000_3004, 0, 1, I0,   32'h3004,     32'h3000,     I0,    1, 0, 1);
    // Redirect is not captured while stalled
    cyc(0, 1, 32'h0000_3200, 1, 0, JUNK, 32'h3004,     32'h3000,     I0,    1, 0, 1);
    cyc(0, 0, 32'h0000_3008, 0, 1, I1,   32'h3008,     32'h3004,     I1,    1, 0, 1);
    // Reset wins over stall
    cyc(1, 1, 32'h0000_3004, 0, 1, I0,   32'h3000,     32'h3000,     32'h0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d queued want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline.
- Owns the PC register and the F/D pipeline register.
- Drives the instruction-memory request.
- Consumes the next-PC value computed from the D-stage branch/jump decision.
- Tolerates a variable-latency instruction memory. It latches a D-stage redirect so the branch is not lost when the delay slot is still being fetched.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, lowest legal instruction address
IM_WORDS, 4096, number of 32-bit words in legal instruction space

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit stall; freezes PC and F/D register
npc  input  32  next PC from the next-PC logic (F_PC+4 or D-stage target)
D_jump  input  1  D-stage instruction is a taken branch/jump (npc != F_PC+4)
imem_req  output  1  fetch request for imem_addr
imem_addr  output  32  word address to fetch, equals F_PC
imem_ready  input  1  imem_rdata valid for imem_addr this cycle
imem_rdata  input  32  fetched instruction
F_PC  output  32  current fetch PC
D_PC  output  32  PC of the instruction in D
D_Instr  output  32  instruction in D (0 = nop when bubble)
D_valid  output  1  D holds a real fetched instruction
D_exc  output  1  D instruction carries an AdEL fetch exception

Behaviour:
- Single clock. All state updates on the posedge clk. Reset is synchronous and active-high. Reset has priority over stall.
- Reset values:
  - F_PC=PC_RESET, D_PC=PC_RESET, D_Instr=0, D_valid=0, D_exc=0.
  - redir_valid=0, redir_pc=0.
- Fetch legality (combinational):
  - bad_pc = (F_PC[1:0]!=0) | F_PC<IM_BASE | F_PC>=IM_BASE+4*IM_WORDS.
  - Compare in 33-bit arithmetic, so no wrap-around at 0xFFFF_FFFC.
- Outputs toward memory:
  - imem_req = !reset & !bad_pc.
  - imem_addr = F_PC.
  - imem_addr is stable while imem_req=1 and fetch has not completed.
- fetch_done = bad_pc | imem_ready. A bad PC completes immediately without a memory access.
- Cycle priorities (first match wins):
  1. stall=1: F_PC, D_*, redir_* all hold. imem_ready is ignored. Memory keeps ready asserted until the address changes. The redirect is not captured (the npc may still depend on unresolved operands).
  2. stall=0, fetch_done=0:
     - Inject a bubble into D: D_Instr=0, D_valid=0, D_exc=0, D_PC=F_PC.
     - F_PC holds.
     - If D_valid & D_jump & !redir_valid: redir_valid<=1, redir_pc<=npc.
  3. stall=0, fetch_done=1:
     - D_Instr <= bad_pc ? 0 : imem_rdata.
     - D_PC <= F_PC; D_valid <= 1; D_exc <= bad_pc.
     - F_PC <= redir_valid ? redir_pc : npc.
     - redir_valid <= 0.
- Delay-slot semantics: a branch in D with a completing fetch lets the delay slot (F_PC) enter D and loads the target into F_PC in the same edge. This needs no latch.
- D_jump is qualified with D_valid. A bubble in D never redirects.
- A redirect captured in case 2 is applied at the first completing fetch after it, i.e. after the delay slot.
- Only one redirect can be pending. After capture, D holds bubbles until that fetch completes, so a second capture cannot occur.
- Reset mid-wait: the pending redirect is discarded and fetch restarts at PC_RESET.
- Reset latency: the first instruction appears in D one cycle after the first cycle with reset=0 and imem_ready=1.
- npc arithmetic belongs to the next-PC logic. This block only selects between npc and redir_pc.

Decomposition:
- Shared package holds PC_RESET, IM_BASE, IM_WORDS defaults, the NOP encoding (32'h0) and the AdEL exception code constant.
- Natural sub-module: fd_reg, the F/D pipeline register with hold (stall), bubble-inject and load controls.
- PC, redirect latch and legality check stay in fetch_stage.

Test Plan:
- Reset with imem_ready=1 every cycle, npc=F_PC+4:
  - F_PC steps 0x3000, 0x3004, 0x3008.
  - D_PC lags by one cycle; D_valid=1 from the second cycle.
- stall=1 for 3 cycles at F_PC=0x3008 → F_PC, D_PC, D_Instr unchanged; imem_addr stays 0x3008.
- Branch at 0x3004 in D, D_jump=1, npc=0x3100, imem_ready=1:
  - Next edge: D_PC=0x3008 (delay slot), F_PC=0x3100.
- Same branch, but imem_ready=0 for 2 cycles on 0x3008:
  - D gets bubbles (D_valid=0); redir_pc=0x3100 is captured.
  - When ready rises: D_PC=0x3008, then F_PC=0x3100.
- Branch target npc=0x3102 (misaligned):
  - imem_req=0; next edge D_exc=1, D_Instr=0, D_PC=0x3102.
  - F_PC=0x3106 (npc=F_PC+4). The F_PC=0x3106 fetch also completes with D_exc=1.
- Reset asserted while redir_valid=1 and waiting → after release F_PC=0x3000 and redirect not applied.
